// File: rtl/uart_tx_serializer_gen.sv
// +----------------------------------------------------------------------------+
// | uart_tx_serializer_gen                                                     |
// | Run-time length/bit-order parallel-to-serial shifter for the UART TX path. |
// | Optional parity generation: define SER_PARITY_EN.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_serializer_gen #(
  parameter int MAX_WIDTH = 8,
  parameter int LEN_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [MAX_WIDTH-1:0] P_DATA,
  input  logic                 DATA_VALID,
  output logic                 data_ready,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 lsb_first,
  input  logic                 ser_en,
`ifdef SER_PARITY_EN
  input  logic                 par_type,
  output logic                 par_bit,
`endif
  output logic                 ser_data,
  output logic                 ser_done,
  output logic                 busy
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [MAX_WIDTH-1:0]   shreg_q, shreg_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   lsb_q, lsb_d;
  logic                   ser_data_q, ser_data_d;
  logic [LEN_WIDTH-1:0]   len_eff;
  logic [LEN_WIDTH-1:0]   shamt;
  logic                   load;

  // Out-of-range lengths (0 or above MAX_WIDTH) fall back to a full-width frame.
  always_comb begin
    len_eff = frame_len;
    if (frame_len == '0 || frame_len > MAX_LEN) begin
      len_eff = MAX_LEN;
    end
    shamt = MAX_LEN - len_eff;
  end

  assign data_ready = (state_q != S_SHIFT);
  assign busy       = (state_q == S_SHIFT);
  assign ser_done   = (state_q == S_DONE);
  assign ser_data   = ser_data_q;
  assign load       = DATA_VALID && data_ready;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    lsb_d      = lsb_q;
    ser_data_d = ser_data_q;
    if (load) begin
      state_d = S_SHIFT;
      cnt_d   = len_eff;
      lsb_d   = lsb_first;
      // MSB-first frames are left-aligned so bit L-1 leaves from the top.
      shreg_d = lsb_first ? P_DATA : (P_DATA << shamt);
    end else if (state_q == S_SHIFT && ser_en) begin
      if (lsb_q) begin
        ser_data_d = shreg_q[0];
        shreg_d    = shreg_q >> 1;
      end else begin
        ser_data_d = shreg_q[MAX_WIDTH-1];
        shreg_d    = shreg_q << 1;
      end
      cnt_d = cnt_q - LEN_WIDTH'(1);
      if (cnt_q == LEN_WIDTH'(1)) begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      lsb_q      <= 1'b0;
      ser_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      lsb_q      <= lsb_d;
      ser_data_q <= ser_data_d;
    end
  end

`ifdef SER_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic [MAX_WIDTH-1:0] par_mask;

  always_comb begin
    par_mask  = {MAX_WIDTH{1'b1}} >> shamt;
    par_bit_d = par_bit_q;
    if (load) begin
      par_bit_d = (^(P_DATA & par_mask)) ^ par_type;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_bit_q <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
    end
  end

  assign par_bit = par_bit_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_serializer_gen.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_serializer_gen                                                  |
// | Directed self-checking bench for uart_tx_serializer_gen.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_serializer_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       data_ready;
  logic [3:0] frame_len = '0;
  logic       lsb_first = 1'b0;
  logic       ser_en = 1'b0;
  logic       ser_data;
  logic       ser_done;
  logic       busy;
  logic       par_type = 1'b0;
`ifdef SER_PARITY_EN
  logic       par_bit;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_serializer_gen #(.MAX_WIDTH(8), .LEN_WIDTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .data_ready (data_ready),
    .frame_len  (frame_len),
    .lsb_first  (lsb_first),
    .ser_en     (ser_en),
`ifdef SER_PARITY_EN
    .par_type   (par_type),
    .par_bit    (par_bit),
`endif
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer one word with ser_en low; the handshake completes on the next edge.
  task automatic load(input logic [7:0] d, input logic [3:0] len, input logic lsb,
                      input logic exp_prev_bit);
    P_DATA     = d;
    frame_len  = len;
    lsb_first  = lsb;
    ser_en     = 1'b0;
    DATA_VALID = 1'b1;
    #1;
    check("ready_before_load", {15'd0, data_ready}, 16'd1);
    tick();
    DATA_VALID = 1'b0;
    check("busy_after_load", {15'd0, busy}, 16'd1);
    check("ready_after_load", {15'd0, data_ready}, 16'd0);
    check("done_after_load", {15'd0, ser_done}, 16'd0);
    check("data_held_at_load", {15'd0, ser_data}, {15'd0, exp_prev_bit});
  endtask

  // seq bit i is the i-th bit expected on ser_data.
  task automatic shift_all(input string tag, input logic [15:0] seq, input int n);
    ser_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, "_bit"}, {15'd0, ser_data}, {15'd0, seq[i]});
      check({tag, "_done"}, {15'd0, ser_done}, {15'd0, (i == n - 1)});
      check({tag, "_busy"}, {15'd0, busy}, {15'd0, (i != n - 1)});
      check({tag, "_ready"}, {15'd0, data_ready}, {15'd0, (i == n - 1)});
    end
    ser_en = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ser_data", {15'd0, ser_data}, 16'd0);
    check("rst_ser_done", {15'd0, ser_done}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_ready", {15'd0, data_ready}, 16'd1);
    @(negedge CLK);
    RST = 1'b1;
    tick();

    // A5 LSB-first: 1,0,1,0,0,1,0,1
    load(8'hA5, 4'd8, 1'b1, 1'b0);
    shift_all("a5_lsb", 16'h00A5, 8);

    // DONE ignores ser_en and holds the last bit
    ser_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold_data", {15'd0, ser_data}, 16'd1);
      check("done_hold_done", {15'd0, ser_done}, 16'd1);
    end
    ser_en = 1'b0;

    // A5 MSB-first: 1,0,1,0,0,1,0,1
    load(8'hA5, 4'd8, 1'b0, 1'b1);
    shift_all("a5_msb", 16'h00A5, 8);
    // 3C MSB-first: 0,0,1,1,1,1,0,0
    load(8'h3C, 4'd8, 1'b0, 1'b1);
    shift_all("3c_msb", 16'h003C, 8);
    // F3 len 5 LSB-first: 1,1,0,0,1
    load(8'hF3, 4'd5, 1'b1, 1'b0);
    shift_all("f3_len5", 16'h0013, 5);
    // 96 len 0 MSB-first -> full 8 bits: 1,0,0,1,0,1,1,0
    load(8'h96, 4'd0, 1'b0, 1'b1);
    shift_all("96_len0", 16'h0069, 8);
    // FA len 3 MSB-first: bits 2,1,0 -> 0,1,0
    load(8'hFA, 4'd3, 1'b0, 1'b0);
    shift_all("fa_len3", 16'h0002, 3);
    // 5A len 12 (over range) LSB-first -> 8 bits: 0,1,0,1,1,0,1,0
    load(8'h5A, 4'd12, 1'b1, 1'b0);
    shift_all("5a_len12", 16'h005A, 8);

    // Baud-tick strobes, DATA_VALID held and inputs disturbed during SHIFT.
    // C5 LSB-first: 1,0,1,0,0,0,1,1
    load(8'hC5, 4'd8, 1'b1, 1'b0);
    DATA_VALID = 1'b1;
    P_DATA     = 8'h00;
    frame_len  = 4'd2;
    lsb_first  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] seq;
      seq    = 8'hC5;
      ser_en = 1'b1;
      tick();
      ser_en = 1'b0;
      if (i == 7) DATA_VALID = 1'b0;
      check("baud_bit", {15'd0, ser_data}, {15'd0, seq[i]});
      check("baud_done", {15'd0, ser_done}, {15'd0, (i == 7)});
      if (i < 7) begin
        for (int j = 0; j < 15; j++) begin
          tick();
          check("baud_stable", {15'd0, ser_data}, {15'd0, seq[i]});
          check("baud_busy", {15'd0, busy}, 16'd1);
        end
      end
    end
    tick();
    check("baud_done_hold", {15'd0, ser_done}, 16'd1);

    // Back-to-back from DONE: 81 LSB-first: 1,0,0,0,0,0,0,1
    load(8'h81, 4'd8, 1'b1, 1'b1);
    tick();
    check("b2b_no_strobe_hold", {15'd0, ser_data}, 16'd1);
    shift_all("b2b_81", 16'h0081, 8);

    // Reset mid-frame after 3 bits of FF
    load(8'hFF, 4'd8, 1'b1, 1'b1);
    ser_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("pre_rst_bit", {15'd0, ser_data}, 16'd1);
    RST = 1'b0;
    #1;
    check("mid_rst_data", {15'd0, ser_data}, 16'd0);
    check("mid_rst_done", {15'd0, ser_done}, 16'd0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, data_ready}, 16'd1);
    @(negedge CLK);
    RST = 1'b1;
    // IDLE ignores ser_en
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_busy", {15'd0, busy}, 16'd0);
      check("idle_data", {15'd0, ser_data}, 16'd0);
    end
    ser_en = 1'b0;
    load(8'h0F, 4'd4, 1'b1, 1'b0);
    shift_all("after_rst_0f", 16'h000F, 4);

`ifdef SER_PARITY_EN
    par_type = 1'b0;
    load(8'h07, 4'd8, 1'b1, 1'b1);
    check("par_even", {15'd0, par_bit}, 16'd1);
    shift_all("par_even_07", 16'h0007, 8);
    par_type = 1'b1;
    load(8'h07, 4'd8, 1'b1, 1'b0);
    check("par_odd", {15'd0, par_bit}, 16'd0);
    shift_all("par_odd_07", 16'h0007, 8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
